// File: rtl/program_loader.sv
// Boot-time loader: parses a header + data + instruction word stream into preload
// write strobes for the core's data and instruction memories, then releases the core.
module program_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] instruction,
  output logic [6:0]  instructionAddress,
  output logic        writeEnable,
  output logic [31:0] data,
  output logic [6:0]  dataAddress,
  output logic        dataWriteEnable,
  output logic        cpu_run,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle, StHdr, StData, StInstr, StFlush, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  ni_q, nd_q;
  logic [6:0]  icount_q, dcount_q;

  logic        hs;
  logic [7:0]  hdr_ni, hdr_nd;
  logic        hdr_bad, hdr_empty;
  logic        last_data, last_instr, is_final, last_ok;
  logic        ld_hdr, wr_data, wr_instr;
  logic        in_ready_d, cpu_run_d, error_d;

  assign hs        = in_valid && in_ready;
  assign hdr_ni    = in_word[7:0];
  assign hdr_nd    = in_word[15:8];
  assign hdr_bad   = (hdr_ni > 8'd128) || (hdr_nd > 8'd128);
  assign hdr_empty = (hdr_ni == 8'd0) && (hdr_nd == 8'd0);
  // Counts are at most 128, so count-1 always fits the 7-bit counters.
  assign last_data  = ({1'b0, dcount_q} == (nd_q - 8'd1));
  assign last_instr = ({1'b0, icount_q} == (ni_q - 8'd1));

  // Whether the word currently offered is the final word of the image.
  always_comb begin
    is_final = 1'b0;
    case (state_q)
      StHdr:   is_final = hdr_empty;
      StData:  is_final = last_data && (ni_q == 8'd0);
      StInstr: is_final = last_instr;
      default: is_final = 1'b0;
    endcase
  end

  assign last_ok = (in_last == is_final);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StHdr;
      end
      StHdr: begin
        if (hs) begin
          if (hdr_bad || !last_ok) state_d = StErr;
          else if (hdr_empty)      state_d = StFlush;
          else if (hdr_nd != 8'd0) state_d = StData;
          else                     state_d = StInstr;
        end
      end
      StData: begin
        if (hs) begin
          if (!last_ok)       state_d = StErr;
          else if (last_data) state_d = (ni_q != 8'd0) ? StInstr : StFlush;
        end
      end
      StInstr: begin
        if (hs) begin
          if (!last_ok)        state_d = StErr;
          else if (last_instr) state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone: begin
        if (start) state_d = StHdr;
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; flags are registered from the next state so they track state_q exactly.
  always_comb begin
    in_ready_d = (state_d == StHdr) || (state_d == StData) || (state_d == StInstr);
    // cpu_run needs a full cycle in DONE, and drops on the edge that takes start.
    cpu_run_d  = (state_q == StDone) && (state_d == StDone);
    error_d    = (state_d == StErr);
    ld_hdr     = (state_q == StHdr) && hs;
    wr_data    = (state_q == StData) && hs && last_ok;
    wr_instr   = (state_q == StInstr) && hs && last_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready           <= 1'b0;
      cpu_run            <= 1'b0;
      error              <= 1'b0;
      writeEnable        <= 1'b0;
      dataWriteEnable    <= 1'b0;
      instruction        <= 32'd0;
      instructionAddress <= 7'd0;
      data               <= 32'd0;
      dataAddress        <= 7'd0;
      ni_q               <= 8'd0;
      nd_q               <= 8'd0;
      icount_q           <= 7'd0;
      dcount_q           <= 7'd0;
    end else begin
      in_ready        <= in_ready_d;
      cpu_run         <= cpu_run_d;
      error           <= error_d;
      writeEnable     <= 1'b0;
      dataWriteEnable <= 1'b0;
      if (ld_hdr) begin
        ni_q     <= hdr_ni;
        nd_q     <= hdr_nd;
        icount_q <= 7'd0;
        dcount_q <= 7'd0;
      end
      if (wr_data) begin
        data            <= in_word;
        dataAddress     <= dcount_q;
        dataWriteEnable <= 1'b1;
        dcount_q        <= dcount_q + 7'd1;
      end
      if (wr_instr) begin
        instruction        <= in_word;
        instructionAddress <= icount_q;
        writeEnable        <= 1'b1;
        icount_q           <= icount_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of image shapes plus random images, checked against
// a stream-level parse of each image.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [31:0] in_word;
  logic        in_ready, writeEnable, dataWriteEnable, cpu_run, error;
  logic [31:0] instruction, data;
  logic [6:0]  instructionAddress, dataAddress;

  always #5 clk = ~clk;

  program_loader dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .in_valid           (in_valid),
    .in_word            (in_word),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .instruction        (instruction),
    .instructionAddress (instructionAddress),
    .writeEnable        (writeEnable),
    .data               (data),
    .dataAddress        (dataAddress),
    .dataWriteEnable    (dataWriteEnable),
    .cpu_run            (cpu_run),
    .error              (error)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;
  int run_rise = -100;
  logic prev_run = 1'b0;
  logic [38:0] dut_d[$];
  logic [38:0] dut_i[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor away from the active edge.
  always @(negedge clk) begin
    if (dataWriteEnable) dut_d.push_back({dataAddress, data});
    if (writeEnable) dut_i.push_back({instructionAddress, instruction});
    if (in_valid && in_ready) last_acc <= cyc + 1;
    if (cpu_run && !prev_run) run_rise <= cyc;
    prev_run <= cpu_run;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int ni;
    int nd;
    int bad;      // stream index whose in_last is flipped, -1 for none
    int gap;      // idle cycles between words, -1 for random
    bit fixed;    // use the fixed three-word program
    bit chain;    // continue from previous image without reset
    bit exp_err;
    int exp_nd;
    int exp_ni;
  } vec_t;

  task automatic run_image(input int ni, input int nd, input int bad, input int gap,
                           input bit fixed, input bit chain, input bit use_tab,
                           input bit t_err, input int t_nd, input int t_ni,
                           input string tag);
    logic [31:0] w[$];
    bit          l[$];
    logic [38:0] exp_d[$];
    logic [38:0] exp_i[$];
    int total, n_acc, g, t, bw;
    bit m_err, e_err;
    int e_nd, e_ni;

    total = 1 + nd + ni;
    w.push_back({16'($urandom), 8'(nd), 8'(ni)});
    for (int k = 1; k < total; k++) w.push_back($urandom);
    if (fixed) begin
      w[1] = 32'd12;
      w[2] = 32'h8C010000;
      w[3] = 32'h20420003;
    end
    for (int k = 0; k < total; k++) l.push_back((k == total - 1) ^ (k == bad));

    // Reference: walk the stream, stop at the first malformed word.
    m_err = 1'b0;
    n_acc = 0;
    for (int k = 0; k < total; k++) begin
      n_acc = k + 1;
      if (k == 0 && (ni > 128 || nd > 128)) begin
        m_err = 1'b1;
        break;
      end
      if (l[k] != (k == total - 1)) begin
        m_err = 1'b1;
        break;
      end
      if (k >= 1 && k <= nd) exp_d.push_back({7'(k - 1), w[k]});
      else if (k > nd) exp_i.push_back({7'(k - 1 - nd), w[k]});
    end
    e_err = use_tab ? t_err : m_err;
    e_nd  = use_tab ? t_nd : exp_d.size();
    e_ni  = use_tab ? t_ni : exp_i.size();

    dut_d.delete();
    dut_i.delete();
    run_rise = -100;
    if (!chain) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (chain) check({tag, "_run_drop"}, cpu_run, 0);

    for (int k = 0; k < n_acc; k++) begin
      in_valid = 1'b1;
      in_word  = w[k];
      in_last  = l[k];
      t = 0;
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      if (!in_ready) begin
        check({tag, "_ready_timeout"}, in_ready, 1);
        break;
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) tick();
    end
    repeat (6) tick();

    check({tag, "_error"}, error, e_err);
    check({tag, "_cpu_run"}, cpu_run, !e_err);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_dwrites"}, dut_d.size(), e_nd);
    check({tag, "_iwrites"}, dut_i.size(), e_ni);
    bw = 0;
    for (int i = 0; i < exp_d.size() && i < dut_d.size(); i++)
      if (dut_d[i] !== exp_d[i]) bw++;
    for (int i = 0; i < exp_i.size() && i < dut_i.size(); i++)
      if (dut_i[i] !== exp_i[i]) bw++;
    check({tag, "_words"}, bw, 0);
    if (!e_err) check({tag, "_run_latency"}, 64'(run_rise - last_acc), 64'(2));
    else begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check({tag, "_err_sticky"}, {error, cpu_run, in_ready}, 3'b100);
    end
  endtask

  vec_t tab[12];

  initial begin
    tab[0]  = '{2,   1,   -1, 0,  1'b1, 1'b0, 1'b0, 1,   2};
    tab[1]  = '{2,   1,   -1, 3,  1'b1, 1'b0, 1'b0, 1,   2};
    tab[2]  = '{3,   0,   2,  0,  1'b0, 1'b0, 1'b1, 0,   1};
    tab[3]  = '{129, 0,   -1, 0,  1'b0, 1'b0, 1'b1, 0,   0};
    tab[4]  = '{0,   0,   -1, 0,  1'b0, 1'b0, 1'b0, 0,   0};
    tab[5]  = '{128, 0,   -1, 0,  1'b0, 1'b1, 1'b0, 0,   128};
    tab[6]  = '{0,   5,   -1, 1,  1'b0, 1'b0, 1'b0, 5,   0};
    tab[7]  = '{4,   128, -1, 0,  1'b0, 1'b0, 1'b0, 128, 4};
    tab[8]  = '{0,   0,   0,  0,  1'b0, 1'b0, 1'b1, 0,   0};
    tab[9]  = '{2,   3,   1,  0,  1'b0, 1'b0, 1'b1, 0,   0};
    tab[10] = '{1,   2,   -1, -1, 1'b0, 1'b0, 1'b0, 2,   1};
    tab[11] = '{0,   200, -1, 0,  1'b0, 1'b0, 1'b1, 0,   0};

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_word = 32'd0;
    repeat (2) tick();
    check("rst_flags", {in_ready, writeEnable, dataWriteEnable, cpu_run, error}, 5'b0);
    check("rst_instr", {instruction, instructionAddress}, 39'd0);
    check("rst_data", {data, dataAddress}, 39'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", in_ready, 0);

    for (int i = 0; i < 12; i++)
      run_image(tab[i].ni, tab[i].nd, tab[i].bad, tab[i].gap, tab[i].fixed, tab[i].chain,
                1'b1, tab[i].exp_err, tab[i].exp_nd, tab[i].exp_ni, $sformatf("tab%0d", i));

    // Reset after two of four instruction words, then reload from address 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_word  = (k == 0) ? 32'h0000_0004 : $urandom;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_flags", {in_ready, writeEnable, dataWriteEnable, cpu_run, error}, 5'b0);
    check("midrst_instr", {instruction, instructionAddress}, 39'd0);
    check("midrst_data", {data, dataAddress}, 39'd0);
    run_image(4, 0, -1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4, "midrst_reload");

    for (int r = 0; r < 15; r++) begin
      int ni, nd, bad;
      ni  = $urandom_range(0, 12);
      nd  = $urandom_range(0, 12);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ni + nd)) : -1;
      run_image(ni, nd, bad, -1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
